// File: rtl/dmem_ctrl.sv
// dmem_ctrl: core data port to single-port SRAM bridge with window decode, wait states and sticky bus error.
// Latency 3+WAIT_CYC cycles in window, 1 out of window; one access in flight, requests held until the ready pulse.
module dmem_ctrl #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          WAIT_CYC  = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [31:0]       d_addr,
  input  logic              d_wr_req,
  output logic              d_wr_ready,
  input  logic              d_rd_req,
  output logic              d_rd_ready,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wr_data,
  output logic [31:0]       d_rd_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [31:0]       err_addr,
  input  logic              err_clr
);

  localparam logic [31:0] WIN_MASK  = ~((32'd4 << ADDR_W) - 32'd1);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  localparam logic [1:0]  ERR_OOW   = 2'b01;
  localparam logic [1:0]  ERR_DUAL  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPT, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } mem_req_t;

  typedef struct packed {
    logic        flag;
    logic [1:0]  code;
    logic [31:0] addr;
  } err_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rd_ready_q, rd_ready_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        mem_cs_q, mem_cs_d;
  mem_req_t    mem_req_q, mem_req_d;
  err_t        err_q, err_d;
  logic        in_win;

  assign in_win = (d_addr & WIN_MASK) == BASE_ADDR;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    wr_ready_d = 1'b0;
    rd_ready_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_cs_d   = 1'b0;
    mem_req_d  = mem_req_q;
    mem_req_d.we = 1'b0;
    err_d      = err_q;
    // A clear is overridden below by any error detected in the same cycle.
    if (err_clr) begin
      err_d = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (d_wr_req || d_rd_req) begin
          op_wr_d = d_wr_req;
          if (!in_win) begin
            state_d    = S_RESP;
            wr_ready_d = d_wr_req;
            rd_ready_d = !d_wr_req;
            if (!d_wr_req) begin
              rd_data_d = '0;
            end
            err_d = '{flag: 1'b1, code: ERR_OOW, addr: d_addr};
          end else begin
            state_d   = S_ISSUE;
            mem_cs_d  = 1'b1;
            mem_req_d = '{we: d_wr_req, addr: d_addr[ADDR_W+1:2], be: d_be, wdata: d_wr_data};
            if (d_wr_req && d_rd_req) begin
              err_d = '{flag: 1'b1, code: ERR_DUAL, addr: d_addr};
            end
          end
        end
      end
      S_ISSUE: state_d = S_CAPT;
      S_CAPT: begin
        if (!op_wr_q) begin
          rd_data_d = mem_rdata;
        end
        if (WAIT_CYC == 0) begin
          state_d    = S_RESP;
          wr_ready_d = op_wr_q;
          rd_ready_d = !op_wr_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_RESP;
          wr_ready_d = op_wr_q;
          rd_ready_d = !op_wr_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
      mem_cs_q   <= 1'b0;
      mem_req_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      mem_cs_q   <= mem_cs_d;
      mem_req_q  <= mem_req_d;
      err_q      <= err_d;
    end
  end

  assign d_wr_ready = wr_ready_q;
  assign d_rd_ready = rd_ready_q;
  assign d_rd_data  = rd_data_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_req_q.we;
  assign mem_addr   = mem_req_q.addr;
  assign mem_be     = mem_req_q.be;
  assign mem_wdata  = mem_req_q.wdata;
  assign err        = err_q.flag;
  assign err_code   = err_q.code;
  assign err_addr   = err_q.addr;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 3 wait states) with an SRAM model each,
// a transaction-level reference model and one per-cycle compare routine.
module tb_dmem_ctrl;

  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstb;
  logic [1:0]          d_wr_req, d_rd_req, err_clr;
  logic [1:0][31:0]    d_addr, d_wr_data;
  logic [1:0][3:0]     d_be;
  logic [1:0]          d_wr_ready, d_rd_ready, mem_cs, mem_we, err;
  logic [1:0][31:0]    d_rd_data, mem_wdata, err_addr;
  logic [1:0][AW-1:0]  mem_addr;
  logic [1:0][3:0]     mem_be;
  logic [1:0][1:0]     err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: the access in flight per instance, expected memory, read data and error state.
  bit          act[2];
  int          t0[2], tlat[2];
  bit          twr[2], tinw[2];
  logic [31:0] taddr[2], twd[2], texp[2];
  logic [3:0]  tbe[2];
  logic [1:0]  tcode[2];
  logic [31:0] ref_mem[2][16];
  logic [31:0] last_rd[2];
  bit          e_err[2], n_err[2];
  logic [1:0]  e_code[2], n_code[2];
  logic [31:0] e_addr[2], n_addr[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] sram [4096];
    logic [31:0] rdata;

    dmem_ctrl #(.ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYC(g * 3)) u_dut (
      .clk(clk), .rstb(rstb),
      .d_addr(d_addr[g]), .d_wr_req(d_wr_req[g]), .d_wr_ready(d_wr_ready[g]),
      .d_rd_req(d_rd_req[g]), .d_rd_ready(d_rd_ready[g]), .d_be(d_be[g]),
      .d_wr_data(d_wr_data[g]), .d_rd_data(d_rd_data[g]),
      .mem_cs(mem_cs[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_be(mem_be[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rdata),
      .err(err[g]), .err_code(err_code[g]), .err_addr(err_addr[g]), .err_clr(err_clr[g])
    );

    // Read data is garbage except in the cycle after a read strobe.
    always @(posedge clk) begin
      if (mem_cs[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[g][b]) sram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
      end
      if (mem_cs[g] && !mem_we[g]) rdata <= sram[mem_addr[g]];
      else rdata <= $urandom;
    end
  end

  function automatic int wait_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + (32'd4 << AW));
  endfunction

  task automatic chk(input int u, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL u%0d %s cyc=%0d: got %0h, want %0h", u, nm, cyc, got, want);
    end
  endtask

  task automatic cmp();
    bit ecs, ewr, erd, busy;
    for (int u = 0; u < 2; u++) begin
      if (!rstb) begin
        chk(u, "reset_outputs_zero",
            32'(|{d_wr_ready[u], d_rd_ready[u], d_rd_data[u], mem_cs[u], mem_we[u], mem_addr[u],
                  mem_be[u], mem_wdata[u], err[u], err_code[u], err_addr[u]}), 32'd0);
        last_rd[u] = '0;
        e_err[u] = 1'b0; e_code[u] = '0; e_addr[u] = '0;
        n_err[u] = 1'b0; n_code[u] = '0; n_addr[u] = '0;
      end else begin
        e_err[u] = n_err[u]; e_code[u] = n_code[u]; e_addr[u] = n_addr[u];
        ecs  = act[u] && tinw[u] && (cyc == t0[u] + 1);
        ewr  = act[u] && twr[u] && (cyc == t0[u] + tlat[u]);
        erd  = act[u] && !twr[u] && (cyc == t0[u] + tlat[u]);
        busy = act[u] && !twr[u] && (cyc > t0[u]) && (cyc < t0[u] + tlat[u]);
        chk(u, "mem_cs", 32'(mem_cs[u]), 32'(ecs));
        chk(u, "d_wr_ready", 32'(d_wr_ready[u]), 32'(ewr));
        chk(u, "d_rd_ready", 32'(d_rd_ready[u]), 32'(erd));
        if (ecs) begin
          chk(u, "mem_we", 32'(mem_we[u]), 32'(twr[u]));
          chk(u, "mem_addr", 32'(mem_addr[u]), 32'(taddr[u][AW+1:2]));
          chk(u, "mem_be", 32'(mem_be[u]), 32'(tbe[u]));
          chk(u, "mem_wdata", mem_wdata[u], twd[u]);
        end
        if (erd) begin
          chk(u, "d_rd_data_at_ready", d_rd_data[u], texp[u]);
          last_rd[u] = texp[u];
        end else if (!busy) begin
          chk(u, "d_rd_data_hold", d_rd_data[u], last_rd[u]);
        end
        chk(u, "err", 32'(err[u]), 32'(e_err[u]));
        chk(u, "err_code", 32'(err_code[u]), 32'(e_code[u]));
        chk(u, "err_addr", err_addr[u], e_addr[u]);
        if (act[u] && cyc == t0[u] && tcode[u] != 2'b00) begin
          n_err[u] = 1'b1; n_code[u] = tcode[u]; n_addr[u] = taddr[u];
        end else if (err_clr[u]) begin
          n_err[u] = 1'b0; n_code[u] = '0; n_addr[u] = '0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drop(input int u);
    d_wr_req[u] = 1'b0;
    d_rd_req[u] = 1'b0;
    err_clr[u]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      drop(0);
      drop(1);
    end
  endtask

  task automatic start(input int u, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit clr);
    d_wr_req[u] = wr; d_rd_req[u] = rd; d_addr[u] = a;
    d_be[u] = be; d_wr_data[u] = wd; err_clr[u] = clr;
    act[u]  = 1'b1;
    t0[u]   = cyc;
    twr[u]  = wr;
    tinw[u] = in_win(a);
    tlat[u] = tinw[u] ? 3 + wait_of(u) : 1;
    taddr[u] = a; tbe[u] = be; twd[u] = wd;
    tcode[u] = !tinw[u] ? 2'b01 : ((wr && rd) ? 2'b10 : 2'b00);
    if (!wr) begin
      texp[u] = tinw[u] ? ref_mem[u][a[5:2]] : 32'h0;
    end else if (tinw[u]) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[u][a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic access(input int u, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input bit clr,
                        output int lat, output logic [31:0] rdata, output logic [AW-1:0] cs_addr);
    step();
    drop(0);
    drop(1);
    start(u, wr, rd, a, be, wd, clr);
    lat = -1;
    rdata = '0;
    cs_addr = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      err_clr[u] = 1'b0;
      if (k == 1) cs_addr = mem_addr[u];
      if (d_wr_ready[u] || d_rd_ready[u]) begin
        lat = k;
        rdata = d_rd_data[u];
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL u%0d ready_timeout addr=%h: got no ready in 40 cycles, want one at %0d", u, a, tlat[u]);
      act[u] = 1'b0;
      drop(u);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd, a;
    logic [AW-1:0] ca;
    int u, kind;

    rstb = 1'b0;
    d_wr_req = '0; d_rd_req = '0; err_clr = '0;
    d_addr = '0; d_wr_data = '0; d_be = '0;
    act[0] = 1'b0; act[1] = 1'b0;
    repeat (3) step();
    rstb = 1'b1;

    for (int uu = 0; uu < 2; uu++) begin
      for (int i = 0; i < 16; i++) begin
        access(uu, 1'b1, 1'b0, BASE + 32'(i * 4), 4'hF, $urandom, 1'b0, lat, rd, ca);
      end
    end

    access(0, 1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'hA5A5_1234, 1'b0, lat, rd, ca);
    chk(0, "wr_latency_w0", 32'(lat), 32'd3);
    chk(0, "wr_mem_addr", 32'(ca), 32'd4);
    access(0, 1'b0, 1'b1, 32'h0001_0010, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    chk(0, "rd_latency_w0", 32'(lat), 32'd3);
    chk(0, "rd_data_word", rd, 32'hA5A5_1234);
    access(0, 1'b1, 1'b0, 32'h0001_0010, 4'b0100, 32'h00CC_0000, 1'b0, lat, rd, ca);
    access(0, 1'b0, 1'b1, 32'h0001_0012, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    chk(0, "rd_data_byte_merge", rd, 32'hA5CC_1234);

    access(1, 1'b0, 1'b1, 32'h0001_0020, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    chk(1, "rd_latency_w3", 32'(lat), 32'd6);

    access(0, 1'b0, 1'b1, 32'h0002_0000, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    chk(0, "oow_latency", 32'(lat), 32'd1);
    chk(0, "oow_rd_data", rd, 32'h0);
    chk(0, "oow_err", 32'(err[0]), 32'd1);
    chk(0, "oow_err_code", 32'(err_code[0]), 32'd1);
    chk(0, "oow_err_addr", err_addr[0], 32'h0002_0000);
    step();
    drop(0);
    drop(1);
    err_clr[0] = 1'b1;
    step();
    err_clr[0] = 1'b0;
    chk(0, "err_after_clr", 32'(err[0]), 32'd0);

    access(0, 1'b0, 1'b1, 32'h0002_0000, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    access(0, 1'b1, 1'b0, 32'h0003_0000, 4'hF, 32'hDEAD_BEEF, 1'b1, lat, rd, ca);
    chk(0, "collision_err", 32'(err[0]), 32'd1);
    chk(0, "collision_err_addr", err_addr[0], 32'h0003_0000);

    access(0, 1'b1, 1'b1, 32'h0001_0004, 4'hF, 32'h1111_2222, 1'b0, lat, rd, ca);
    chk(0, "dual_latency", 32'(lat), 32'd3);
    chk(0, "dual_err_code", 32'(err_code[0]), 32'd2);

    step();
    drop(0);
    drop(1);
    start(0, 1'b0, 1'b1, 32'h0001_0010, 4'hF, 32'h0, 1'b0);
    step();
    chk(0, "issue_cs_before_reset", 32'(mem_cs[0]), 32'd1);
    rstb = 1'b0;
    act[0] = 1'b0;
    act[1] = 1'b0;
    drop(0);
    repeat (3) step();
    rstb = 1'b1;
    access(0, 1'b0, 1'b1, 32'h0001_0010, 4'hF, 32'h0, 1'b0, lat, rd, ca);
    chk(0, "reissue_latency", 32'(lat), 32'd3);
    chk(0, "reissue_rd_data", rd, 32'hA5CC_1234);

    for (int n = 0; n < 300; n++) begin
      u = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 6) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0001_4000 + 32'($urandom_range(0, 255) * 4);
          1:       a = 32'h0000_FFFC;
          default: a = $urandom | 32'h8000_0000;
        endcase
      end else begin
        a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end
      access(u, kind <= 3 || kind == 9, kind >= 4, a, 4'($urandom), $urandom,
             $urandom_range(0, 9) == 0, lat, rd, ca);
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's data port (d_addr/d_wr_req/d_rd_req/d_be/d_wr_data and the returned d_*_ready/d_rd_data).
- Decodes the word-aligned address against a single SRAM window and drives a synchronous single-port SRAM (1-cycle read latency) with byte enables.
- Inserts programmable wait states and returns a one-cycle ready pulse.
- Out-of-window accesses are terminated without touching the SRAM and recorded in a sticky error register.

Parameters:
- ADDR_W, 12, SRAM word-address width (window = 4*2^ADDR_W bytes).
- BASE_ADDR, 32'h0001_0000, byte base of the SRAM window; must be aligned to the window size.
- WAIT_CYC, 0, extra wait cycles per SRAM access; legal range 0..15.

Ports:
- clk  in  1  clock
- rstb  in  1  async active-low reset
- d_addr  in  32  byte address from core
- d_wr_req  in  1  write request, held until d_wr_ready
- d_wr_ready  out  1  one-cycle write-complete pulse
- d_rd_req  in  1  read request, held until d_rd_ready
- d_rd_ready  out  1  one-cycle read-complete pulse; d_rd_data valid this cycle
- d_be  in  4  byte enables
- d_wr_data  in  32  write data
- d_rd_data  out  32  read data (capture register)
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM word address
- mem_be  out  4  SRAM byte enables
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_cs with mem_we=0
- err  out  1  sticky bus-error flag
- err_code  out  2  01 out-of-window, 10 simultaneous rd+wr request
- err_addr  out  32  d_addr of the most recent error
- err_clr  in  1  clears err, err_code and err_addr

Behaviour:
- Clock and reset: one clock, clk. Reset rstb is asynchronous, active-low.
- Reset values: all outputs 0, including d_rd_data and err_addr. FSM goes to IDLE and the wait counter clears.
- Reset asserted mid-access aborts the access. No ready pulse is issued and the core must reissue.
- All outputs are registered.
- FSM states:
  - IDLE: sample requests.
  - ISSUE: mem_cs=1 for exactly one cycle. mem_we = write. mem_addr = d_addr[ADDR_W+1:2]. mem_be = d_be. mem_wdata = d_wr_data.
  - CAPT: reads load d_rd_data <= mem_rdata. Writes do nothing.
  - WAIT: counts WAIT_CYC cycles. Skipped when WAIT_CYC=0.
  - RESP: asserts the matching ready for exactly one cycle, then returns to IDLE.
- In-window timing (request first sampled in IDLE at cycle T):
  - ISSUE at T+1, CAPT at T+2, RESP at T+2+WAIT_CYC+1.
  - With WAIT_CYC=0, ready is at T+3.
- Back-to-back: the core changes or drops its request in the cycle after ready. IDLE at RESP+1 samples afresh, so a new request is accepted with no bubble beyond IDLE.
- Window test: (d_addr & ~(4*2^ADDR_W-1)) == BASE_ADDR.
- Out-of-window access:
  - IDLE -> RESP directly, so ready comes at T+1.
  - mem_cs stays 0.
  - Reads return d_rd_data = 32'h0. Writes are dropped.
  - Sets err=1, err_code=01, err_addr=d_addr.
- d_addr[1:0] are ignored. Byte selection is by d_be only, and d_be=0 performs an SRAM cycle that changes no bytes.
- Simultaneous d_wr_req and d_rd_req in IDLE:
  - The write is serviced and only d_wr_ready pulses.
  - Sets err=1, err_code=10, err_addr=d_addr.
  - If the address is also out of window, err_code=01 takes precedence.
- d_rd_data holds its last captured value. It changes only in CAPT of a read or at an out-of-window read (loads 0).
- err is sticky until err_clr, which takes effect the next cycle. If a new error and err_clr occur in the same cycle, the new error wins and its fields are loaded.
- Requests arriving outside IDLE are ignored. The core protocol guarantees they are held.

Test Plan:
- WAIT_CYC=0: write 0x0001_0010, be=4'hF, data 0xA5A5_1234, then read the same address.
  - Write: mem_cs at T+1 with mem_addr=4, d_wr_ready at T+3.
  - Read: d_rd_ready at T+3 with d_rd_data=0xA5A5_1234.
- Byte write to 0x0001_0010, be=4'b0100, data 0x00CC_0000, then read -> 0xA5CC_1234.
- WAIT_CYC=3: read 0x0001_0020 -> mem_cs exactly one cycle, d_rd_ready at T+6, single-cycle pulse.
- Read 0x0002_0000 (outside 0x10000-0x13FFF):
  - d_rd_ready at T+1, d_rd_data=0, mem_cs never asserted.
  - err=1, err_code=01, err_addr=0x0002_0000.
  - err_clr pulse -> err=0 next cycle.
- Error/clear collision and dual request:
  - Out-of-window write coincident with err_clr -> err stays 1 with the new err_addr.
  - rd+wr requested together at 0x0001_0004 -> only d_wr_ready pulses, err_code=10.
- rstb low at ISSUE of a read -> no d_rd_ready, all outputs 0. After release, a reissued read completes at T+3.
